// File: rtl/brick_pkg.sv
// Shared geometry, colours and FSM state type for the brick playfield.
package brick_pkg;

  localparam int unsigned BOXES_PER_ROW = 10;
  localparam int unsigned NUM_ROWS      = 2;
  localparam int unsigned BRICK_W       = 16;
  localparam int unsigned BRICK_H       = 10;
  localparam int unsigned Y_OFFSET      = 0;
  localparam int unsigned NUM_BRICKS    = BOXES_PER_ROW * NUM_ROWS;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned X_W    = 8;
  localparam int unsigned Y_W    = 7;
  localparam int unsigned COL_W  = 3;
  localparam int unsigned ROW_W  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  localparam logic [COL_W-1:0] COL_BG = 3'b000;
  // Entry r is the paint colour of brick row r.
  localparam logic [NUM_ROWS-1:0][COL_W-1:0] ROW_COLOUR = {3'b110, 3'b100};

  typedef enum logic [1:0] {
    StInit,
    StIdle,
    StErase,
    StClear
  } brick_state_e;

  // Left pixel column of a brick.
  function automatic logic [X_W-1:0] brick_x(input logic [ADDR_W-1:0] idx);
    int unsigned col;
    col = 32'(idx) % BOXES_PER_ROW;
    return X_W'(col * BRICK_W);
  endfunction

  // Top pixel row of a brick.
  function automatic logic [Y_W-1:0] brick_y(input logic [ADDR_W-1:0] idx);
    int unsigned row;
    row = 32'(idx) / BOXES_PER_ROW;
    return Y_W'(Y_OFFSET + row * BRICK_H);
  endfunction

  // Paint colour of a brick; indices past the field map to background.
  function automatic logic [COL_W-1:0] brick_colour(input logic [ADDR_W-1:0] idx);
    int unsigned row;
    row = 32'(idx) / BOXES_PER_ROW;
    if (row < NUM_ROWS) begin
      return ROW_COLOUR[ROW_W'(row)];
    end
    return COL_BG;
  endfunction

endpackage

// File: rtl/brick_rect_walker.sv
// Walks one Width x Height rectangle in raster order, one pixel per cycle.
// A start pulse emits pixel (0,0) in the same cycle, so back-to-back walks have no gap.
module brick_rect_walker
  import brick_pkg::*;
#(
  parameter int unsigned Width  = BRICK_W,
  parameter int unsigned Height = BRICK_H
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic           clear_i,
  input  logic [X_W-1:0] base_x_i,
  input  logic [Y_W-1:0] base_y_i,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o,
  output logic           valid_o,
  output logic           done_o,
  output logic           busy_o
);

  localparam int unsigned PxW = $clog2(Width);
  localparam int unsigned PyW = $clog2(Height);

  logic [PxW-1:0] px_q, px_d, px_cur;
  logic [PyW-1:0] py_q, py_d, py_cur;
  logic           busy_q, busy_d, busy_eff;
  logic           last_px, last_py;

  // Current pixel and next counter values; clear drops a walk, start begins a fresh one.
  always_comb begin
    busy_eff = busy_q & ~clear_i;
    px_cur   = (start_i | clear_i) ? '0 : px_q;
    py_cur   = (start_i | clear_i) ? '0 : py_q;
    valid_o  = start_i | busy_eff;
    last_px  = (px_cur == PxW'(Width - 1));
    last_py  = (py_cur == PyW'(Height - 1));
    done_o   = valid_o & last_px & last_py;
    x_o      = base_x_i + X_W'(px_cur);
    y_o      = base_y_i + Y_W'(py_cur);

    px_d   = px_cur;
    py_d   = py_cur;
    busy_d = busy_eff;
    if (valid_o) begin
      if (done_o) begin
        busy_d = 1'b0;
        px_d   = '0;
        py_d   = '0;
      end else begin
        busy_d = 1'b1;
        if (last_px) begin
          px_d = '0;
          py_d = py_cur + 1'b1;
        end else begin
          px_d = px_cur + 1'b1;
        end
      end
    end
  end

  assign busy_o = busy_q;

  // Pixel counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      px_q   <= '0;
      py_q   <= '0;
      busy_q <= 1'b0;
    end else begin
      px_q   <= px_d;
      py_q   <= py_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/brick_state_manager.sv
// Owns the brick-alive bitmap: paints the field, clears hit bricks, keeps score and
// erases cleared bricks on the VGA adapter one pixel per clock.
module brick_state_manager
  import brick_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start_level,
  input  logic                  hit_valid,
  input  logic [ADDR_W-1:0]     hit_addr,
  output logic                  hit_ready,
  output logic [NUM_BRICKS-1:0] block_state,
  output logic [ADDR_W-1:0]     bricks_left,
  output logic [15:0]           score,
  output logic                  level_clear,
  output logic [X_W-1:0]        x,
  output logic [Y_W-1:0]        y,
  output logic [COL_W-1:0]      colour,
  output logic                  plot
);

  localparam logic [ADDR_W-1:0] NumBricksA = ADDR_W'(NUM_BRICKS);

  brick_state_e          state_q, state_d;
  logic [ADDR_W-1:0]     init_idx_q, init_idx_d;
  logic [ADDR_W-1:0]     erase_idx_q, erase_idx_d;
  logic [NUM_BRICKS-1:0] block_q, block_d;
  logic [ADDR_W-1:0]     left_q, left_d;
  logic [15:0]           score_q, score_d;
  logic [X_W-1:0]        x_q;
  logic [Y_W-1:0]        y_q;
  logic [COL_W-1:0]      colour_q;
  logic                  plot_q;

  logic                  walk_start, walk_clear, walk_valid, walk_done, walk_busy;
  logic [ADDR_W-1:0]     walk_idx;
  logic [X_W-1:0]        walk_x;
  logic [Y_W-1:0]        walk_y;
  logic [COL_W-1:0]      pix_colour;
  logic [NUM_BRICKS-1:0] alive_vec;
  logic                  hit_fire, hit_live;

  assign hit_ready = (state_q == StIdle) && !start_level;
  assign hit_fire  = hit_valid && hit_ready;
  assign alive_vec = block_q >> hit_addr;
  assign hit_live  = (hit_addr < NumBricksA) && alive_vec[0];

  brick_rect_walker #(
    .Width (BRICK_W),
    .Height(BRICK_H)
  ) u_walker (
    .clk_i   (clock),
    .rst_i   (reset),
    .start_i (walk_start),
    .clear_i (walk_clear),
    .base_x_i(brick_x(walk_idx)),
    .base_y_i(brick_y(walk_idx)),
    .x_o     (walk_x),
    .y_o     (walk_y),
    .valid_o (walk_valid),
    .done_o  (walk_done),
    .busy_o  (walk_busy)
  );

  // Choose which brick the walker covers and the colour it paints.
  always_comb begin
    walk_start = 1'b0;
    walk_clear = 1'b0;
    walk_idx   = init_idx_q;
    pix_colour = COL_BG;
    if (start_level) begin
      walk_start = 1'b1;
      walk_clear = 1'b1;
      walk_idx   = '0;
      pix_colour = brick_colour('0);
    end else begin
      case (state_q)
        StInit: begin
          walk_idx   = init_idx_q;
          pix_colour = brick_colour(init_idx_q);
          walk_start = !walk_busy && (init_idx_q < NumBricksA);
        end
        StIdle: begin
          walk_idx   = hit_addr;
          walk_start = hit_fire && hit_live;
        end
        StErase: walk_idx = erase_idx_q;
        default: ;
      endcase
    end
  end

  // Next-state logic for the FSM, bitmap and counters.
  always_comb begin
    state_d     = state_q;
    init_idx_d  = init_idx_q;
    erase_idx_d = erase_idx_q;
    block_d     = block_q;
    left_d      = left_q;
    score_d     = score_q;
    if (start_level) begin
      state_d    = StInit;
      init_idx_d = '0;
      block_d    = '1;
      left_d     = NumBricksA;
    end else begin
      case (state_q)
        StInit: begin
          // One idle cycle after the last brick keeps hit_ready low through the final plot.
          if (init_idx_q == NumBricksA) begin
            state_d = StIdle;
          end else if (walk_done) begin
            init_idx_d = init_idx_q + 1'b1;
          end
        end
        StIdle: begin
          if (hit_fire && hit_live) begin
            block_d     = block_q & ~(NUM_BRICKS'(1) << hit_addr);
            left_d      = left_q - 1'b1;
            score_d     = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
            erase_idx_d = hit_addr;
            state_d     = StErase;
          end
        end
        StErase: begin
          if (!walk_busy) begin
            state_d = (left_q == '0) ? StClear : StIdle;
          end
        end
        default: ;
      endcase
    end
  end

  // State, bitmap and counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StInit;
      init_idx_q  <= '0;
      erase_idx_q <= '0;
      block_q     <= '1;
      left_q      <= NumBricksA;
      score_q     <= '0;
    end else begin
      state_q     <= state_d;
      init_idx_q  <= init_idx_d;
      erase_idx_q <= erase_idx_d;
      block_q     <= block_d;
      left_q      <= left_d;
      score_q     <= score_d;
    end
  end

  // Registered VGA plot port; coordinates hold while nothing is plotted.
  always_ff @(posedge clock) begin
    if (reset) begin
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
    end else begin
      plot_q <= walk_valid;
      if (walk_valid) begin
        x_q      <= walk_x;
        y_q      <= walk_y;
        colour_q <= pix_colour;
      end
    end
  end

  assign block_state = block_q;
  assign bricks_left = left_q;
  assign score       = score_q;
  assign level_clear = (state_q == StClear);
  assign x           = x_q;
  assign y           = y_q;
  assign colour      = colour_q;
  assign plot        = plot_q;

endmodule

// File: tb/tb_brick_state_manager.sv
// Directed bench for brick_state_manager; expected plots are queued when stimulus is driven
// and compared as the DUT plots them.
module tb_brick_state_manager;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_level;
  logic        hit_valid;
  logic [4:0]  hit_addr;
  logic        hit_ready;
  logic [19:0] block_state;
  logic [4:0]  bricks_left;
  logic [15:0] score;
  logic        level_clear;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;

  int checks = 0;
  int errors = 0;

  logic [17:0] exp_q[$];
  logic [19:0] bm;
  logic [4:0]  left_m;
  logic [15:0] score_m;

  brick_state_manager dut (
    .clock      (clock),
    .reset      (reset),
    .start_level(start_level),
    .hit_valid  (hit_valid),
    .hit_addr   (hit_addr),
    .hit_ready  (hit_ready),
    .block_state(block_state),
    .bricks_left(bricks_left),
    .score      (score),
    .level_clear(level_clear),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_brick(input int b, input logic [2:0] c);
    int xx, yy;
    for (int py = 0; py < 10; py++) begin
      for (int px = 0; px < 16; px++) begin
        xx = (b % 10) * 16 + px;
        yy = (b / 10) * 10 + py;
        exp_q.push_back({8'(xx), 7'(yy), c});
      end
    end
  endtask

  task automatic push_init();
    for (int b = 0; b < 20; b++) begin
      push_brick(b, (b < 10) ? 3'b100 : 3'b110);
    end
  endtask

  // One clock; while pixels are owed the DUT must plot the next one, otherwise stay quiet.
  task automatic tick();
    logic [17:0] e;
    @(posedge clock);
    #1;
    if (exp_q.size() != 0) begin
      check("plot_gap", 32'(plot), 32'(1));
      if (plot === 1'b1) begin
        e = exp_q.pop_front();
        check("pixel_xyc", 32'({x, y, colour}), 32'(e));
      end
    end else begin
      check("plot_spurious", 32'(plot), 32'(0));
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      check("ready_while_busy", 32'(hit_ready), 32'(0));
      n++;
    end
    check("drain_left", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic check_state(input string tag);
    check({tag, "_bitmap"}, 32'(block_state), 32'(bm));
    check({tag, "_left"}, 32'(bricks_left), 32'(left_m));
    check({tag, "_score"}, 32'(score), 32'(score_m));
  endtask

  task automatic do_hit(input logic [4:0] addr);
    logic live;
    live = 1'b0;
    hit_valid = 1'b1;
    hit_addr  = addr;
    #1;
    check("ready_idle", 32'(hit_ready), 32'(1));
    if (addr < 5'd20) begin
      if (bm[addr]) live = 1'b1;
    end
    if (live) begin
      bm[addr] = 1'b0;
      left_m   = left_m - 5'd1;
      if (score_m != 16'hFFFF) score_m = score_m + 16'd1;
      push_brick(int'(addr), 3'b000);
    end
    tick();
    hit_valid = 1'b0;
    check_state("hit");
    if (live) begin
      drain(400);
      tick();
      check("ready_after_erase", 32'(hit_ready), 32'(left_m != 5'd0));
    end else begin
      tick();
      check("ready_after_dead", 32'(hit_ready), 32'(1));
    end
  endtask

  initial begin
    reset       = 1'b1;
    start_level = 1'b0;
    hit_valid   = 1'b0;
    hit_addr    = '0;
    bm          = 20'hFFFFF;
    left_m      = 5'd20;
    score_m     = 16'd0;

    // Reset state, then the initial paint.
    tick();
    check_state("reset");
    check("reset_level_clear", 32'(level_clear), 32'(0));
    check("reset_xyc", 32'({x, y, colour}), 32'(0));
    check("reset_ready", 32'(hit_ready), 32'(0));
    reset = 1'b0;
    push_init();
    drain(4000);
    tick();
    check("ready_after_init", 32'(hit_ready), 32'(1));
    check_state("init");

    // Live hit, repeated dead hit, out-of-range hit.
    do_hit(5'd12);
    do_hit(5'd12);
    do_hit(5'd25);

    // Clear every brick and reach level clear.
    for (int i = 0; i < 20; i++) begin
      do_hit(5'(i));
    end
    check("clear_level_clear", 32'(level_clear), 32'(1));
    check("clear_ready", 32'(hit_ready), 32'(0));
    check_state("clear");
    tick();
    tick();
    check("clear_held", 32'(level_clear), 32'(1));
    hit_valid = 1'b1;
    hit_addr  = 5'd3;
    #1;
    check("clear_ready_hit", 32'(hit_ready), 32'(0));
    tick();
    hit_valid = 1'b0;
    check_state("clear_hit");

    // New level: repaint, score kept.
    start_level = 1'b1;
    #1;
    check("start_ready", 32'(hit_ready), 32'(0));
    exp_q.delete();
    push_init();
    tick();
    start_level = 1'b0;
    bm     = 20'hFFFFF;
    left_m = 5'd20;
    check("restart_level_clear", 32'(level_clear), 32'(0));
    check_state("restart");
    drain(4000);
    tick();
    check("ready_after_repaint", 32'(hit_ready), 32'(1));

    // start_level lands on the 50th erase pixel with a hit pending.
    hit_valid = 1'b1;
    hit_addr  = 5'd7;
    #1;
    check("abort_ready_idle", 32'(hit_ready), 32'(1));
    bm[7]   = 1'b0;
    left_m  = 5'd19;
    score_m = score_m + 16'd1;
    push_brick(7, 3'b000);
    tick();
    hit_valid = 1'b0;
    for (int i = 0; i < 48; i++) begin
      tick();
    end
    start_level = 1'b1;
    hit_valid   = 1'b1;
    hit_addr    = 5'd3;
    #1;
    check("abort_ready", 32'(hit_ready), 32'(0));
    exp_q.delete();
    push_init();
    tick();
    start_level = 1'b0;
    hit_valid   = 1'b0;
    bm     = 20'hFFFFF;
    left_m = 5'd20;
    check_state("abort");
    drain(4000);
    tick();
    check("ready_after_abort", 32'(hit_ready), 32'(1));
    check_state("abort_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
